// File: rtl/fp_add_scheduler.sv
// Round-robin scheduler sharing one pipelined FP adder among N_REQ requesters.
// A tag pipeline matched to the adder latency routes each result back to its requester.
module fp_add_scheduler #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned LATENCY = 6
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [N_REQ-1:0]           req_vld_i,
    input  logic [N_REQ*32-1:0]        req_a_i,
    input  logic [N_REQ*32-1:0]        req_b_i,
    output logic [N_REQ-1:0]           req_rdy_o,
    input  logic                       hold_i,
    output logic [31:0]                add_a_o,
    output logic [31:0]                add_b_o,
    output logic                       add_vld_o,
    input  logic [31:0]                add_result_i,
    input  logic [1:0]                 add_state_i,
    input  logic                       add_res_vld_i,
    output logic [N_REQ-1:0]           rsp_vld_o,
    output logic [31:0]                rsp_result_o,
    output logic [1:0]                 rsp_state_o,
    output logic [$clog2(N_REQ)+3:0]   inflight_o,
    output logic                       idle_o,
    output logic                       tag_err_o
);

    localparam int unsigned ID_W  = $clog2(N_REQ);
    localparam int unsigned CNT_W = ID_W + 4;

    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  grant_id, cand;
    logic             grant_any;
    logic [31:0]      sel_a, sel_b;

    logic             add_vld_q, add_vld_d;
    logic [31:0]      add_a_q, add_a_d;
    logic [31:0]      add_b_q, add_b_d;

    logic [LATENCY:0] tag_vld_q;
    logic [ID_W-1:0]  tag_id_q [LATENCY+1];

    logic             slot_vld, rsp_fire;
    logic [N_REQ-1:0] rsp_vld_q, rsp_vld_d;
    logic [31:0]      rsp_result_q, rsp_result_d;
    logic [1:0]       rsp_state_q, rsp_state_d;
    logic             tag_err_q, tag_err_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic             dec;

    // Search starts at rr_ptr and wraps; first asserted requester wins.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ID_W'((32'(rr_ptr_q) + 32'(k)) % N_REQ);
            if (!grant_any && req_vld_i[cand]) begin
                grant_any = 1'b1;
                grant_id  = cand;
            end
        end
        if (rst_i || hold_i) begin
            grant_any = 1'b0;
        end
        req_rdy_o = grant_any ? (N_REQ'(1) << grant_id) : '0;
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel_a = req_a_i[32*i +: 32];
                sel_b = req_b_i[32*i +: 32];
            end
        end
    end

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        add_vld_d = grant_any;
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        if (grant_any) begin
            rr_ptr_d = (32'(grant_id) == N_REQ - 1) ? '0 : grant_id + 1'b1;
            add_a_d  = sel_a;
            add_b_d  = sel_b;
        end
    end

    // Slot LATENCY lines up with the adder's res_vld for the same operation.
    always_comb begin
        slot_vld     = tag_vld_q[LATENCY];
        rsp_fire     = add_res_vld_i & slot_vld;
        rsp_vld_d    = rsp_fire ? (N_REQ'(1) << tag_id_q[LATENCY]) : '0;
        rsp_result_d = rsp_fire ? add_result_i : rsp_result_q;
        rsp_state_d  = rsp_fire ? add_state_i : rsp_state_q;
        tag_err_d    = tag_err_q | (add_res_vld_i ^ slot_vld);
    end

    always_comb begin
        dec        = |rsp_vld_q;
        inflight_d = inflight_q;
        case ({grant_any, dec})
            2'b10: begin
                if (inflight_q != '1) begin
                    inflight_d = inflight_q + 1'b1;
                end
            end
            2'b01: begin
                if (inflight_q != '0) begin
                    inflight_d = inflight_q - 1'b1;
                end
            end
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q     <= '0;
            add_vld_q    <= 1'b0;
            add_a_q      <= '0;
            add_b_q      <= '0;
            tag_vld_q    <= '0;
            for (int k = 0; k <= LATENCY; k++) begin
                tag_id_q[k] <= '0;
            end
            rsp_vld_q    <= '0;
            rsp_result_q <= '0;
            rsp_state_q  <= 2'b00;
            tag_err_q    <= 1'b0;
            inflight_q   <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            add_vld_q    <= add_vld_d;
            add_a_q      <= add_a_d;
            add_b_q      <= add_b_d;
            tag_vld_q    <= {tag_vld_q[LATENCY-1:0], grant_any};
            tag_id_q[0]  <= grant_id;
            for (int k = 1; k <= LATENCY; k++) begin
                tag_id_q[k] <= tag_id_q[k-1];
            end
            rsp_vld_q    <= rsp_vld_d;
            rsp_result_q <= rsp_result_d;
            rsp_state_q  <= rsp_state_d;
            tag_err_q    <= tag_err_d;
            inflight_q   <= inflight_d;
        end
    end

    assign add_vld_o    = add_vld_q;
    assign add_a_o      = add_a_q;
    assign add_b_o      = add_b_q;
    assign rsp_vld_o    = rsp_vld_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_state_o  = rsp_state_q;
    assign inflight_o   = inflight_q;
    assign tag_err_o    = tag_err_q;
    assign idle_o       = (inflight_q == '0) && (req_vld_i == '0);

endmodule
